// File: rtl/r200_mem_pkg.sv
// Shared definitions for the r200 data-memory responder: funct3 codes,
// FSM state encoding and the wait-counter width.
package r200_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/r200dmem_align.sv
// Lane selection for the data memory: byte enables and replicated store data
// on the way in, lane extraction and sign/zero extension on the way out.
module r200dmem_align
  import r200_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_sh_c,
  output logic [31:0] rdata_ext_c,
  output logic        err_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = 8'(rword >> {addr_lo, 3'b000});
    half_sel    = addr_lo[1] ? rword[31:16] : rword[15:0];
    be_c        = 4'b0000;
    wdata_sh_c  = 32'h0;
    rdata_ext_c = 32'h0;
    err_c       = 1'b0;
    case (func3)
      F3_B: begin
        be_c        = 4'(4'b0001 << addr_lo);
        wdata_sh_c  = {4{wdata[7:0]}};
        rdata_ext_c = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        be_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh_c  = {2{wdata[15:0]}};
        rdata_ext_c = {{16{half_sel[15]}}, half_sel};
        err_c       = addr_lo[0];
      end
      F3_W: begin
        be_c        = 4'b1111;
        wdata_sh_c  = wdata;
        rdata_ext_c = rword;
        err_c       = |addr_lo;
      end
      // Unsigned variants exist only for loads
      F3_BU: begin
        rdata_ext_c = {24'h0, byte_sel};
        err_c       = we;
      end
      F3_HU: begin
        rdata_ext_c = {16'h0, half_sel};
        err_c       = we | addr_lo[0];
      end
      default: err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/r200dmem.sv
// Data-memory responder for the r200 MEM stage: single outstanding request,
// fixed wait states, one-cycle response pulse with load data or error flag.
module r200dmem
  import r200_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_t           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            func3_q, func3_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;

  logic [31:0]           mem_q [DEPTH_WORDS];

  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [2:0]            acc_func3;
  logic [IDX_W-1:0]      acc_idx;
  logic                  range_err;
  logic [31:0]           rword;
  logic [3:0]            be;
  logic [31:0]           wdata_sh;
  logic [31:0]           rdata_ext;
  logic                  align_err;
  logic                  acc_err;
  logic                  commit;
  logic                  mem_we;

  // With zero wait states the access commits on the accept edge, so the
  // operands come straight from the request rather than the latches.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_func3 = req_func3;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_func3 = func3_q;
    end
    acc_idx   = acc_addr[IDX_W+1:2];
    range_err = (acc_addr[31:2] >= 30'(DEPTH_WORDS));
    rword     = mem_q[acc_idx];
  end

  r200dmem_align u_align (
    .addr_lo     (acc_addr[1:0]),
    .func3       (acc_func3),
    .we          (acc_we),
    .wdata       (acc_wdata),
    .rword       (rword),
    .be_c        (be),
    .wdata_sh_c  (wdata_sh),
    .rdata_ext_c (rdata_ext),
    .err_c       (align_err)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    func3_d      = func3_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    acc_err      = align_err | range_err;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          func3_d = req_func3;
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WAIT_CNT_W'(1);
        if (cnt_q <= WAIT_CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The access happens on the edge that enters RESP
    commit = (state_d == ST_RESP) && (state_q != ST_RESP);
    if (commit) begin
      resp_err_d   = acc_err;
      resp_rdata_d = (acc_err || acc_we) ? 32'h0 : rdata_ext;
    end
    mem_we       = commit && acc_we && !acc_err && rst_n;
    resp_valid_d = (state_d == ST_RESP);
    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = !req_ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      func3_q      <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      func3_q      <= func3_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  // Array has no reset; byte-enable write of the addressed lanes only
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[acc_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_r200dmem.sv
// Self-checking bench for r200dmem: a byte-array reference model predicts
// every load result and error flag; two instances cover 3 and 0 wait states.
module tb_r200dmem;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WA    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [31:0] a_req_addr = 32'h0, a_req_wdata = 32'h0;
  logic [2:0]  a_req_func3 = 3'd0;
  logic        a_req_ready, a_resp_valid, a_resp_err, a_busy;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [31:0] b_req_addr = 32'h0, b_req_wdata = 32'h0;
  logic [2:0]  b_req_func3 = 3'd0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_resp_rdata;

  r200dmem #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .req_func3(a_req_func3), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .busy(a_busy));

  r200dmem #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_func3(b_req_func3), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .busy(b_busy));

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ma [4*DEPTH];

  // Reference: byte-addressed memory, size from funct3, natural alignment rule
  task automatic model_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3,
                              output logic [31:0] r, output logic e);
    int sz;
    logic [31:0] v;
    e = 1'b0; r = 32'h0; sz = 0;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    e = 1'b1;
    endcase
    if (we && f3 > 3'd2) e = 1'b1;
    if (sz != 0 && (addr % sz) != 0) e = 1'b1;
    if (addr >= 4*DEPTH) e = 1'b1;
    if (!e) begin
      if (we) begin
        for (int k = 0; k < sz; k++) ma[addr+k] = wdata[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < sz; k++) v = v | (32'(ma[addr+k]) << (8*k));
        if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        r = v;
      end
    end
  endtask

  // Issue one request on instance A; report response data, latency, pulse width
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output logic narrow);
    @(negedge clk);
    a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_func3 = f3;
    a_req_valid = 1'b1;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    lat = 1;
    while (!a_resp_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    rdata = a_resp_rdata;
    err   = a_resp_err;
    @(posedge clk);
    #1 narrow = !a_resp_valid;
  endtask

  task automatic test_reset;
    n_checks++; if ({a_req_ready, a_busy, a_resp_valid, a_resp_err} !== 4'b1000) $display("FAIL reset_a_ctrl got %b want 1000", {a_req_ready, a_busy, a_resp_valid, a_resp_err}); else n_pass++;
    n_checks++; if (a_resp_rdata !== 32'h0) $display("FAIL reset_a_rdata got %h want 0", a_resp_rdata); else n_pass++;
    n_checks++; if ({b_req_ready, b_busy, b_resp_valid, b_resp_err} !== 4'b1000) $display("FAIL reset_b_ctrl got %b want 1000", {b_req_ready, b_busy, b_resp_valid, b_resp_err}); else n_pass++;
  endtask

  task automatic test_preclear;
    logic [31:0] r, er; logic e, ee, nw; int lat; int bad;
    bad = 0;
    for (int w = 0; w < int'(DEPTH); w++) begin
      model_access(1'b1, 32'(4*w), 32'h0, 3'd2, er, ee);
      do_req(1'b1, 32'(4*w), 32'h0, 3'd2, r, e, lat, nw);
      if (e !== ee || lat != WA + 1) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL preclear bad_responses got %0d want 0", bad); else n_pass++;
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] r; logic e, nw; int lat; int pulses;
    @(negedge clk);
    a_req_we = 1'b1; a_req_addr = 32'h10; a_req_wdata = 32'h1234_5678; a_req_func3 = 3'd2;
    a_req_valid = 1'b1;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({a_req_ready, a_busy, a_resp_valid} !== 3'b100) $display("FAIL rst_mid_wait_ctrl got %b want 100", {a_req_ready, a_busy, a_resp_valid}); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if (a_resp_valid) pulses++;
    end
    n_checks++; if (pulses != 0 || a_req_ready !== 1'b1) $display("FAIL rst_no_resp got pulses=%0d ready=%b want 0 1", pulses, a_req_ready); else n_pass++;
    do_req(1'b0, 32'h10, 32'h0, 3'd2, r, e, lat, nw);
    n_checks++; if (r !== 32'h0 || e !== 1'b0) $display("FAIL rst_dropped_store got %h/%b want 00000000/0", r, e); else n_pass++;
  endtask

  task automatic test_word;
    logic [31:0] r, er; logic e, ee, nw; int lat;
    model_access(1'b1, 32'h40, 32'hDEAD_BEEF, 3'd2, er, ee);
    do_req(1'b1, 32'h40, 32'hDEAD_BEEF, 3'd2, r, e, lat, nw);
    n_checks++; if (e !== 1'b0 || r !== 32'h0) $display("FAIL sw_resp got %h/%b want 00000000/0", r, e); else n_pass++;
    model_access(1'b0, 32'h40, 32'h0, 3'd2, er, ee);
    do_req(1'b0, 32'h40, 32'h0, 3'd2, r, e, lat, nw);
    n_checks++; if (r !== 32'hDEAD_BEEF || e !== 1'b0) $display("FAIL lw_data got %h/%b want deadbeef/0", r, e); else n_pass++;
    n_checks++; if (lat != WA + 1 || nw !== 1'b1) $display("FAIL lw_timing got lat=%0d narrow=%b want %0d 1", lat, nw, WA + 1); else n_pass++;
    n_checks++; if (a_resp_rdata !== 32'hDEAD_BEEF) $display("FAIL rdata_hold got %h want deadbeef", a_resp_rdata); else n_pass++;
  endtask

  task automatic test_byte_half;
    logic [31:0] r, er; logic e, ee, nw; int lat;
    logic [35:0] vec [7];
    logic [31:0] want [7];
    // {we, func3, addr(32)} with expected load data alongside
    vec[0] = {1'b1, 3'd0, 32'h41}; want[0] = 32'h0;
    vec[1] = {1'b0, 3'd0, 32'h41}; want[1] = 32'hFFFF_FF80;
    vec[2] = {1'b0, 3'd4, 32'h41}; want[2] = 32'h0000_0080;
    vec[3] = {1'b0, 3'd2, 32'h40}; want[3] = 32'hDEAD_80EF;
    vec[4] = {1'b1, 3'd1, 32'h42}; want[4] = 32'h0;
    vec[5] = {1'b0, 3'd1, 32'h42}; want[5] = 32'hFFFF_8001;
    vec[6] = {1'b0, 3'd5, 32'h42}; want[6] = 32'h0000_8001;
    for (int i = 0; i < 7; i++) begin
      model_access(vec[i][35], vec[i][31:0], (i == 0) ? 32'h80 : 32'h8001, vec[i][34:32], er, ee);
      do_req(vec[i][35], vec[i][31:0], (i == 0) ? 32'h80 : 32'h8001, vec[i][34:32], r, e, lat, nw);
      n_checks++; if (r !== want[i] || e !== 1'b0) $display("FAIL lanes_%0d got %h/%b want %h/0", i, r, e, want[i]); else n_pass++;
    end
  endtask

  task automatic test_errors;
    logic [31:0] r, er; logic e, ee, nw; int lat;
    do_req(1'b0, 32'h43, 32'h0, 3'd1, r, e, lat, nw);
    n_checks++; if (e !== 1'b1 || r !== 32'h0) $display("FAIL lh_misaligned got %h/%b want 00000000/1", r, e); else n_pass++;
    n_checks++; if (lat != WA + 1) $display("FAIL err_latency got %0d want %0d", lat, WA + 1); else n_pass++;
    do_req(1'b1, 32'h42, 32'hFFFF_FFFF, 3'd2, r, e, lat, nw);
    n_checks++; if (e !== 1'b1) $display("FAIL sw_misaligned got err=%b want 1", e); else n_pass++;
    model_access(1'b0, 32'h40, 32'h0, 3'd2, er, ee);
    do_req(1'b0, 32'h40, 32'h0, 3'd2, r, e, lat, nw);
    n_checks++; if (r !== 32'h8001_80EF || r !== er || e !== 1'b0) $display("FAIL lw_unchanged got %h want 800180ef", r); else n_pass++;
    do_req(1'b0, 32'h40, 32'h0, 3'd3, r, e, lat, nw);
    n_checks++; if (e !== 1'b1 || r !== 32'h0) $display("FAIL f3_illegal got %h/%b want 00000000/1", r, e); else n_pass++;
    do_req(1'b1, 32'h40, 32'h0, 3'd4, r, e, lat, nw);
    n_checks++; if (e !== 1'b1) $display("FAIL store_f3_illegal got err=%b want 1", e); else n_pass++;
  endtask

  task automatic test_range;
    logic [31:0] r, er, d; logic e, ee, nw; int lat;
    do_req(1'b0, 32'(4*DEPTH), 32'h0, 3'd2, r, e, lat, nw);
    n_checks++; if (e !== 1'b1 || r !== 32'h0) $display("FAIL lw_oob got %h/%b want 00000000/1", r, e); else n_pass++;
    d = $urandom;
    model_access(1'b1, 32'(4*DEPTH-4), d, 3'd2, er, ee);
    do_req(1'b1, 32'(4*DEPTH-4), d, 3'd2, r, e, lat, nw);
    n_checks++; if (e !== 1'b0) $display("FAIL sw_last got err=%b want 0", e); else n_pass++;
    do_req(1'b0, 32'(4*DEPTH-4), 32'h0, 3'd2, r, e, lat, nw);
    n_checks++; if (r !== d || e !== 1'b0) $display("FAIL lw_last got %h/%b want %h/0", r, e, d); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] r, er, a, d; logic e, ee, nw, we; logic [2:0] f3; int lat;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 4*DEPTH + 7));
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      d  = $urandom;
      model_access(we, a, d, f3, er, ee);
      do_req(we, a, d, f3, r, e, lat, nw);
      n_checks++; if (r !== er || e !== ee || lat != WA + 1 || nw !== 1'b1) $display("FAIL rand_%0d we=%b f3=%0d a=%h got %h/%b lat=%0d want %h/%b lat=%0d", i, we, f3, a, r, e, lat, er, ee, WA + 1); else n_pass++;
    end
  endtask

  task automatic test_hold_valid;
    logic [31:0] er; logic ee; int pulses, last, gap_bad, data_bad, rdy_bad;
    model_access(1'b0, 32'h40, 32'h0, 3'd2, er, ee);
    pulses = 0; last = -1; gap_bad = 0; data_bad = 0; rdy_bad = 0;
    @(negedge clk);
    a_req_we = 1'b0; a_req_addr = 32'h40; a_req_func3 = 3'd2; a_req_valid = 1'b1;
    for (int i = 1; i <= 5 * (WA + 2); i++) begin
      @(posedge clk);
      #1;
      if (a_req_ready === a_busy) rdy_bad++;
      if (a_resp_valid) begin
        pulses++;
        if (a_resp_rdata !== er) data_bad++;
        if (last >= 0 && i - last != WA + 2) gap_bad++;
        last = i;
      end
    end
    a_req_valid = 1'b0;
    n_checks++; if (pulses != 5) $display("FAIL hold_pulses got %0d want 5", pulses); else n_pass++;
    n_checks++; if (gap_bad != 0 || data_bad != 0 || rdy_bad != 0) $display("FAIL hold_spacing got gap=%0d data=%0d rdy=%0d want 0 0 0", gap_bad, data_bad, rdy_bad); else n_pass++;
    repeat (WA + 3) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    b_req_we = 1'b1; b_req_addr = 32'h20; b_req_wdata = d; b_req_func3 = 3'd2; b_req_valid = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({b_resp_valid, b_resp_err, b_req_ready, b_busy} !== 4'b1001) $display("FAIL b2b_sw_resp got %b want 1001", {b_resp_valid, b_resp_err, b_req_ready, b_busy}); else n_pass++;
    b_req_we = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if ({b_resp_valid, b_req_ready} !== 2'b01) $display("FAIL b2b_gap got %b want 01", {b_resp_valid, b_req_ready}); else n_pass++;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    n_checks++; if (b_resp_valid !== 1'b1 || b_resp_rdata !== d || b_resp_err !== 1'b0) $display("FAIL b2b_lw got v=%b %h/%b want 1 %h/0", b_resp_valid, b_resp_rdata, b_resp_err, d); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (b_resp_valid !== 1'b0 || b_resp_rdata !== d) $display("FAIL b2b_pulse got v=%b %h want 0 %h", b_resp_valid, b_resp_rdata, d); else n_pass++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    test_preclear;
    test_reset_mid_wait;
    test_word;
    test_byte_half;
    test_errors;
    test_range;
    test_random;
    test_hold_valid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
